// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add sequential multiplier, signed/unsigned, optional early termination
module seq_multiplier #(
    parameter int WIDTH      = 8,
    parameter int EARLY_TERM = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    // Datapath helpers for the current CALC step.
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     mplier_sh;
    logic                 last_step;

    // One shift-and-add step; the multiplier's sign bit carries negative weight in signed mode,
    // so the final partial product is subtracted instead of added.
    always_comb begin
        addend    = mplier_q[0] ? mcand_q : '0;
        acc_step  = (mode_q && (cnt_q == LAST_CNT)) ? (acc_q - addend) : (acc_q + addend);
        mplier_sh = mplier_q >> 1;
        last_step = (cnt_q == LAST_CNT) || ((EARLY_TERM != 0) && (mplier_sh == '0));
    end

    // Next-state and register-update logic for the IDLE/CALC controller.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{signed_mode & a[WIDTH-1]}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    mode_d   = signed_mode;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_sh;
                cnt_d    = cnt_q + CW'(1);
                if (last_step) begin
                    product_d = acc_step;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier (three configurations)
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [3];
    logic        sm_v    [3];
    logic [31:0] a_v     [3];
    logic [31:0] b_v     [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [15:0] p0;
    logic [15:0] p1;
    logic [31:0] p2;
    logic [63:0] prod_v  [3];

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    // Model state per instance.
    bit          m_busy [3];
    bit          m_done [3];
    logic [63:0] m_prod [3];
    logic [63:0] m_pend [3];
    int          m_rem  [3];

    always #5 clk = ~clk;

    // Instance 0: WIDTH=8 early-terminating; 1: WIDTH=8 fixed latency; 2: WIDTH=16 fixed latency.
    seq_multiplier #(.WIDTH(8), .EARLY_TERM(1)) u_w8_et (
        .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .busy(busy_v[0]), .done(done_v[0]), .product(p0));
    seq_multiplier #(.WIDTH(8), .EARLY_TERM(0)) u_w8_fix (
        .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .busy(busy_v[1]), .done(done_v[1]), .product(p1));
    seq_multiplier #(.WIDTH(16), .EARLY_TERM(0)) u_w16_fix (
        .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm_v[2]),
        .a(a_v[2][15:0]), .b(b_v[2][15:0]), .busy(busy_v[2]), .done(done_v[2]), .product(p2));

    assign prod_v[0] = {48'd0, p0};
    assign prod_v[1] = {48'd0, p1};
    assign prod_v[2] = {32'd0, p2};

    function automatic int wid(int i);
        return (i == 2) ? 16 : 8;
    endfunction

    function automatic bit et(int i);
        return (i == 0);
    endfunction

    // Mathematical product, reduced modulo 2^(2w).
    function automatic logic [63:0] ref_prod(int w, bit s, logic [31:0] x, logic [31:0] y);
        longint xs;
        longint ys;
        longint p;
        logic [63:0] mask;
        xs = longint'(x) & ((longint'(1) << w) - 1);
        ys = longint'(y) & ((longint'(1) << w) - 1);
        if (s && x[w-1]) xs = xs - (longint'(1) << w);
        if (s && y[w-1]) ys = ys - (longint'(1) << w);
        p = xs * ys;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    // Cycles from start to done: highest set multiplier bit + 1 (min 1) when terminating early.
    function automatic int ref_lat(int w, bit e, logic [31:0] y);
        int lat;
        if (!e) return w;
        lat = 1;
        for (int j = 0; j < w; j++) if (y[j]) lat = j + 1;
        return lat;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: advances once per rising edge from the same inputs the DUTs see.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_prod[i] = '0;
                m_rem[i]  = 0;
            end else begin
                m_done[i] = 1'b0;
                if (m_busy[i]) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_prod[i] = m_pend[i];
                    end
                end else if (start_v[i]) begin
                    m_pend[i] = ref_prod(wid(i), sm_v[i], a_v[i], b_v[i]);
                    m_rem[i]  = ref_lat(wid(i), et(i), b_v[i]);
                    m_busy[i] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy[%0d]", i), 64'(busy_v[i]), 64'(m_busy[i]));
                chk($sformatf("done[%0d]", i), 64'(done_v[i]), 64'(m_done[i]));
                chk($sformatf("product[%0d]", i), prod_v[i], m_prod[i]);
            end
        end
    end

    // Waits (bounded) for done on instance i; returns cycles counted after the start edge.
    task automatic wait_done(int i, output int n);
        n = 0;
        while (!done_v[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(int i, bit s, logic [31:0] x, logic [31:0] y,
                          logic [63:0] ep, int ek);
        int n;
        start_v[i] = 1'b1;
        sm_v[i]    = s;
        a_v[i]     = x;
        b_v[i]     = y;
        @(negedge clk);
        start_v[i] = 1'b0;
        wait_done(i, n);
        chk($sformatf("latency[%0d] %0h*%0h", i, x, y), 64'(n), 64'(ek));
        chk($sformatf("result[%0d] %0h*%0h", i, x, y), prod_v[i], ep);
        @(negedge clk);
    endtask

    logic [31:0] vec_a [6] = '{32'h00, 32'hFF, 32'h7F, 32'h81, 32'h0C, 32'hFF};
    logic [31:0] vec_b [6] = '{32'h00, 32'hFF, 32'h7F, 32'h7F, 32'h10, 32'h01};
    bit          vec_s [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            sm_v[i]    = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        armed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset busy[%0d]", i), 64'(busy_v[i]), 64'd0);
            chk($sformatf("reset done[%0d]", i), 64'(done_v[i]), 64'd0);
            chk($sformatf("reset product[%0d]", i), prod_v[i], 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 1'b0, 32'd200, 32'd255, 64'hC738, 8);
        run_op(0, 1'b1, 32'h80, 32'h80, 64'h4000, 8);
        run_op(0, 1'b1, 32'h07, 32'hFD, 64'hFFEB, 8);
        run_op(0, 1'b1, 32'd100, 32'd3, 64'h012C, 2);
        run_op(0, 1'b1, 32'h55, 32'h00, 64'h0000, 1);
        run_op(1, 1'b0, 32'd100, 32'd3, 64'h012C, 8);
        run_op(1, 1'b1, 32'h80, 32'h80, 64'h4000, 8);
        run_op(2, 1'b1, 32'h8000, 32'h7FFF, 64'hC0008000, 16);
        run_op(2, 1'b1, 32'h8000, 32'h8000, 64'h40000000, 16);
        run_op(2, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001, 16);

        for (int v = 0; v < 6; v++) begin
            run_op(0, vec_s[v], vec_a[v], vec_b[v],
                   ref_prod(8, vec_s[v], vec_a[v], vec_b[v]),
                   ref_lat(8, 1'b1, vec_b[v]));
        end

        // Start while busy is ignored; start on the done cycle chains back-to-back.
        start_v[0] = 1'b1; sm_v[0] = 1'b0; a_v[0] = 32'd200; b_v[0] = 32'd255;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        start_v[0] = 1'b1; sm_v[0] = 1'b1; a_v[0] = 32'h05; b_v[0] = 32'h01;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, n);
        chk("ignored start latency", 64'(n + 3), 64'd8);
        chk("ignored start result", prod_v[0], 64'hC738);
        start_v[0] = 1'b1; sm_v[0] = 1'b1; a_v[0] = 32'h07; b_v[0] = 32'hFD;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("back-to-back busy", 64'(busy_v[0]), 64'd1);
        wait_done(0, n);
        chk("back-to-back latency", 64'(n), 64'd8);
        chk("back-to-back result", prod_v[0], 64'hFFEB);
        @(negedge clk);

        // Reset on the third CALC cycle aborts without a done pulse.
        start_v[0] = 1'b1; sm_v[0] = 1'b0; a_v[0] = 32'd200; b_v[0] = 32'd255;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 64'(busy_v[0]), 64'd0);
        chk("abort product", prod_v[0], 64'd0);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (done_v[0]) n++;
            @(negedge clk);
        end
        chk("abort no done", 64'(n), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand width; legal range 2..32.
REQ-002 The block SHALL have parameter EARLY_TERM, default 1; 1 = finish when the remaining multiplier bits are all zero, 0 = fixed WIDTH-cycle latency.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request a multiply; sampled only when busy=0.
REQ-006 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 The block SHALL have port a, input, WIDTH bits: multiplicand; sampled with start.
REQ-008 The block SHALL have port b, input, WIDTH bits: multiplier; sampled with start.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid product.
REQ-011 The block SHALL have port product, output, 2*WIDTH bits: registered result.

Function
REQ-012 The FSM SHALL have two states: IDLE and CALC.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL latch operands into internal registers:
- multiplicand: a extended to 2*WIDTH bits (sign-extended if signed_mode=1, else zero-extended)
- multiplier register: b
- accumulator and bit counter: 0
- mode: signed_mode
It SHALL then enter CALC with busy=1 from E0.
REQ-014 At each CALC edge, if multiplier bit 0 is 1, the accumulator SHALL add the multiplicand, or subtract it when mode is signed and counter = WIDTH-1; arithmetic is modulo 2^(2*WIDTH).
REQ-015 At each CALC edge, the multiplicand SHALL shift left 1, the multiplier SHALL shift right 1 (logical), and the counter SHALL increment.
REQ-016 CALC SHALL exit at the edge where counter = WIDTH-1, or, if EARLY_TERM=1, where the shifted multiplier equals 0.
REQ-017 CALC SHALL always last at least one cycle, including when b=0.
REQ-018 At the exit edge Ek, the block SHALL load product with the final accumulator, set done=1 and busy=0, and return to IDLE.
REQ-019 done SHALL be high for exactly the one cycle after Ek; latency from start edge to done is k cycles, 1 <= k <= WIDTH.
REQ-020 product SHALL hold its value until the next completion; it SHALL NOT change during CALC.
REQ-021 start while busy=1 SHALL be ignored, with no effect on operands or timing.
REQ-022 start in the cycle where done=1 SHALL be accepted, giving back-to-back operation.
REQ-023 Signed results SHALL be exact for all operands, including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL go to IDLE with busy=0, done=0, product=0, and all internal registers 0.
REQ-025 rst SHALL take priority over start.
REQ-026 rst during CALC SHALL abort the operation with no done pulse.

Verification (WIDTH=8 unless stated)
REQ-027 Unsigned a=200, b=255 -> product=0xC738, done 8 cycles after start.
REQ-028 Signed a=0x80, b=0x80 -> product=0x4000 after 8 cycles; signed a=0x07, b=0xFD -> product=0xFFEB after 8 cycles.
REQ-029 Early termination: signed a=100, b=3 -> product=0x012C, done 2 cycles after start; a=0x55, b=0 -> product=0, done after 1 cycle.
REQ-030 Second start while busy, with different operands -> ignored; first result is correct. New start on the done cycle -> second result follows with no idle gap.
REQ-031 rst asserted on the 3rd CALC cycle -> busy=0 and product=0 on the next cycle; done never pulses.
REQ-032 EARLY_TERM=0: a=100, b=3 unsigned -> product=0x012C, done exactly 8 cycles after start; WIDTH=16 signed 0x8000*0x7FFF -> product=0xC0008000.
